// File: rtl/jsc_pkg.sv
// Shared constants and types for the jet-substructure input quantizer.
// Thresholds default to a symmetric split of the signed feature range.
package jsc_pkg;

   localparam int NUM_FEATURES = 16;
   localparam int FEAT_W       = 16;
   localparam int CODE_W       = 2;
   localparam int IDX_W        = 4;
   localparam int NUM_THR      = 3;
   localparam int VEC_W        = NUM_FEATURES * CODE_W;
   localparam int CFG_W        = IDX_W + 2;

   typedef logic signed [FEAT_W-1:0] feat_t;
   typedef logic [CODE_W-1:0]        code_t;
   typedef logic [IDX_W-1:0]         idx_t;
   typedef logic [VEC_W-1:0]         vec_t;

   localparam feat_t THR0_RST = 16'shC000;
   localparam feat_t THR1_RST = 16'sh0000;
   localparam feat_t THR2_RST = 16'sh4000;

   localparam idx_t LAST_IDX = idx_t'(NUM_FEATURES - 1);

   // Configuration address layout: {feature index, threshold select}.
   function automatic idx_t cfg_feat(input logic [CFG_W-1:0] addr);
      return addr[CFG_W-1:2];
   endfunction

   function automatic logic [1:0] cfg_sel(input logic [CFG_W-1:0] addr);
      return addr[1:0];
   endfunction

endpackage

// File: rtl/jsc_feat_quant.sv
// Combinational 2-bit quantizer: counts how many of three thresholds the
// feature meets or exceeds. Threshold order is not enforced.
module jsc_feat_quant
   import jsc_pkg::*;
(
   input  feat_t x,
   input  feat_t t0,
   input  feat_t t1,
   input  feat_t t2,
   output code_t code
);

   logic ge0_s;
   logic ge1_s;
   logic ge2_s;

   // Signed compares against each threshold, summed into the code.
   always_comb begin
      ge0_s = (x >= t0);
      ge1_s = (x >= t1);
      ge2_s = (x >= t2);
      code  = code_t'(ge0_s) + code_t'(ge1_s) + code_t'(ge2_s);
   end

endmodule

// File: rtl/jsc_input_quantizer.sv
// Serial feature quantizer: assembles 16 two-bit codes into one vector with
// valid/ready output, programmable per-feature thresholds and framing checks.
module jsc_input_quantizer
   import jsc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [FEAT_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [VEC_W-1:0]  m_data,
   input  logic              cfg_we,
   input  logic [CFG_W-1:0]  cfg_addr,
   input  logic [FEAT_W-1:0] cfg_data,
   output logic              frame_err
);

   feat_t thr0_q [NUM_FEATURES];
   feat_t thr1_q [NUM_FEATURES];
   feat_t thr2_q [NUM_FEATURES];

   idx_t  idx_q,       idx_d;
   vec_t  asm_q,       asm_d;
   vec_t  m_data_q,    m_data_d;
   logic  m_valid_q,   m_valid_d;
   logic  frame_err_q, frame_err_d;

   code_t code_s;
   logic  beat_acc_s;
   logic  at_last_s;
   idx_t  wr_feat_s;
   logic  [1:0] wr_sel_s;

   assign wr_feat_s  = cfg_feat(cfg_addr);
   assign wr_sel_s   = cfg_sel(cfg_addr);
   assign at_last_s  = (idx_q == LAST_IDX);
   // The final beat may only enter once the held vector can leave this cycle.
   assign s_ready    = !at_last_s || !m_valid_q || m_ready;
   assign beat_acc_s = s_valid && s_ready;

   jsc_feat_quant u_quant (
      .x    (feat_t'(s_data)),
      .t0   (thr0_q[idx_q]),
      .t1   (thr1_q[idx_q]),
      .t2   (thr2_q[idx_q]),
      .code (code_s)
   );

   // Threshold table: defaults on reset, single-entry writes otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FEATURES; i++) begin
            thr0_q[i] <= THR0_RST;
            thr1_q[i] <= THR1_RST;
            thr2_q[i] <= THR2_RST;
         end
      end else if (cfg_we) begin
         case (wr_sel_s)
            2'd0:    thr0_q[wr_feat_s] <= feat_t'(cfg_data);
            2'd1:    thr1_q[wr_feat_s] <= feat_t'(cfg_data);
            2'd2:    thr2_q[wr_feat_s] <= feat_t'(cfg_data);
            default: ;
         endcase
      end
   end

   // Frame assembly, output hold/handoff and framing-error detection.
   always_comb begin
      idx_d       = idx_q;
      asm_d       = asm_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      frame_err_d = 1'b0;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end

      if (beat_acc_s) begin
         if (at_last_s && s_last) begin
            m_data_d = asm_q;
            m_data_d[VEC_W-CODE_W +: CODE_W] = code_s;
            m_valid_d = 1'b1;
            idx_d     = '0;
            asm_d     = '0;
         end else if (!at_last_s && !s_last) begin
            asm_d[{idx_q, 1'b0} +: CODE_W] = code_s;
            idx_d = idx_q + idx_t'(1);
         end else begin
            // Misplaced or missing s_last: drop the partial frame.
            frame_err_d = 1'b1;
            idx_d       = '0;
            asm_d       = '0;
         end
      end else begin
         idx_d = idx_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         asm_q       <= '0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_jsc_input_quantizer.sv
// Scoreboard bench for jsc_input_quantizer: directed frames push expected
// vectors; a negedge monitor pops and compares on every output handshake.
module tb_jsc_input_quantizer;
   import jsc_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [FEAT_W-1:0] s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [VEC_W-1:0]  m_data;
   logic              cfg_we;
   logic [CFG_W-1:0]  cfg_addr;
   logic [FEAT_W-1:0] cfg_data;
   logic              frame_err;

   int n_tests = 0;
   int n_fail  = 0;
   int err_cnt = 0;
   logic [VEC_W-1:0] exp_q[$];

   jsc_input_quantizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (frame_err) err_cnt++;
            if (m_valid && m_ready) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_vector: got %h expected none", m_data);
               end else begin
                  logic [VEC_W-1:0] e;
                  e = exp_q.pop_front();
                  if (m_data !== e) begin
                     n_fail++;
                     $display("FAIL vector: got %h expected %h", m_data, e);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [FEAT_W-1:0] pat_val(input int p, input int i);
      logic signed [FEAT_W-1:0] v;
      case (p)
         0: case (i % 4)
               0:       v = -16'sd20000;
               1:       v = -16'sd1;
               2:       v = 16'sd0;
               default: v = 16'sd16384;
            endcase
         1: v = 16'sd16384;
         2: v = (i % 2 == 0) ? -16'sd20000 : 16'sd0;
         default: v = -16'sd1;
      endcase
      return v;
   endfunction

   // One beat; optionally writes feature 3's T2 in the same cycle.
   task automatic beat(input logic [FEAT_W-1:0] d, input logic last,
                       input logic wr, input logic [FEAT_W-1:0] wr_val);
      int cyc;
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = last;
      cfg_we   = wr;
      cfg_addr = {4'd3, 2'd2};
      cfg_data = wr_val;
      cyc = 0;
      @(negedge clk);
      while (!s_ready && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      if (cyc >= 200) chk("beat_timeout", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      cfg_we  = 1'b0;
   endtask

   task automatic send_frame(input int p, input bit f3_ovr, input logic [FEAT_W-1:0] f3_val,
                             input bit wr3, input logic [FEAT_W-1:0] wr_val,
                             input int nbeats, input int last_pos);
      for (int i = 0; i < nbeats; i++) begin
         beat((f3_ovr && i == 3) ? f3_val : pat_val(p, i), i == last_pos,
              wr3 && i == 3, wr_val);
      end
   endtask

   task automatic cfg_write(input logic [CFG_W-1:0] a, input logic [FEAT_W-1:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic drain(input string name);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int e0;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      m_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      #22;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Default thresholds, four-value pattern.
      exp_q.push_back(32'hE4E4E4E4);
      send_frame(0, 1'b0, '0, 1'b0, '0, 16, 15);
      chk("t1_valid_lat1", 32'(m_valid), 32'd1);
      chk("t1_data_lat1", m_data, 32'hE4E4E4E4);
      @(posedge clk); #1;
      chk("t1_valid_drop", 32'(m_valid), 32'd0);
      drain("t1_drain");

      // Backpressure with overlapping next frame.
      m_ready = 1'b0;
      exp_q.push_back(32'hFFFFFFFF);
      send_frame(1, 1'b0, '0, 1'b0, '0, 16, 15);
      send_frame(2, 1'b0, '0, 1'b0, '0, 15, -1);
      s_valid = 1'b1; s_data = pat_val(2, 15); s_last = 1'b1;
      #2;
      chk("t2_s_ready_low", 32'(s_ready), 32'd0);
      chk("t2_hold_data", m_data, 32'hFFFFFFFF);
      chk("t2_hold_valid", 32'(m_valid), 32'd1);
      exp_q.push_back(32'h88888888);
      m_ready = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      chk("t2_b_valid", 32'(m_valid), 32'd1);
      chk("t2_b_data", m_data, 32'h88888888);
      drain("t2_drain");

      // Early s_last.
      e0 = err_cnt;
      send_frame(0, 1'b0, '0, 1'b0, '0, 6, 5);
      @(posedge clk); #1; @(posedge clk); #1;
      chk("t3_err_pulse", 32'(err_cnt - e0), 32'd1);
      chk("t3_no_valid", 32'(m_valid), 32'd0);
      exp_q.push_back(32'h55555555);
      send_frame(3, 1'b0, '0, 1'b0, '0, 16, 15);
      drain("t3_drain");

      // Missing s_last.
      e0 = err_cnt;
      send_frame(0, 1'b0, '0, 1'b0, '0, 16, -1);
      @(posedge clk); #1; @(posedge clk); #1;
      chk("t4_err_pulse", 32'(err_cnt - e0), 32'd1);
      chk("t4_no_valid", 32'(m_valid), 32'd0);
      exp_q.push_back(32'h88888888);
      send_frame(2, 1'b0, '0, 1'b0, '0, 16, 15);
      drain("t4_drain");

      // Threshold programming on feature 3.
      cfg_write({4'd3, 2'd2}, 16'd100);
      exp_q.push_back(32'h555555D5);
      send_frame(3, 1'b1, 16'd150, 1'b0, '0, 16, 15);
      exp_q.push_back(32'h55555595);
      send_frame(3, 1'b1, 16'd50, 1'b0, '0, 16, 15);
      exp_q.push_back(32'h555555D5);
      send_frame(3, 1'b1, 16'd150, 1'b1, 16'd200, 16, 15);
      exp_q.push_back(32'h55555595);
      send_frame(3, 1'b1, 16'd150, 1'b0, '0, 16, 15);
      drain("t5_drain");

      // Reset mid-frame with a held vector.
      m_ready = 1'b0;
      send_frame(1, 1'b0, '0, 1'b0, '0, 16, 15);
      chk("t6_held_valid", 32'(m_valid), 32'd1);
      send_frame(0, 1'b0, '0, 1'b0, '0, 8, -1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(m_valid), 32'd0);
      chk("t6_rst_data", m_data, 32'h0);
      chk("t6_rst_s_ready", 32'(s_ready), 32'd1);
      #3;
      rst_n = 1'b1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(32'h55555595);
      send_frame(3, 1'b1, 16'd300, 1'b0, '0, 16, 15);
      drain("t6_drain");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jsc_input_quantizer.md
Name: jsc_input_quantizer

Overview:
- Streaming front-end that feeds the first LUT layer of the jet-substructure ensemble.
- Accepts serial signed fixed-point jet features, one per beat, and quantizes each to a 2-bit code against three programmable thresholds.
- Packs 16 codes into a 32-bit vector and presents it, with valid/ready backpressure, as the input bus from which layer-0 neurons take their 6-bit (3 × 2-bit) fan-in slices.

Parameters:
- NUM_FEATURES, 16, features per vector (beats per frame).
- FEAT_W, 16, signed feature width (two's complement).
- CODE_W, 2, code width per feature; fixed at 2 (three thresholds).
- IDX_W, 4, feature index width, equal to clog2(NUM_FEATURES).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  feature beat valid.
- s_ready  out  1  feature beat accepted when s_valid && s_ready.
- s_data  in  FEAT_W  signed feature value.
- s_last  in  1  marks the final feature of a frame.
- m_valid  out  1  packed vector valid.
- m_ready  in  1  downstream accepts the vector when m_valid && m_ready.
- m_data  out  NUM_FEATURES*CODE_W  packed codes; feature i occupies bits [2i+1:2i].
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  IDX_W+2  {feature index, threshold select 0..2}; select 3 is ignored.
- cfg_data  in  FEAT_W  signed threshold value.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (asynchronous, rst_n low) sets:
  - idx=0, assembly register=0, m_valid=0, m_data=0, frame_err=0.
  - Thresholds for every feature: T0=-16384 (0xC000), T1=0, T2=16384 (0x4000).
- Quantization: code = (x>=T0)+(x>=T1)+(x>=T2), using signed compares.
  - Thresholds are assumed ascending.
  - With non-ascending thresholds the count formula is still applied verbatim, with no sorting.
- s_ready = (idx != NUM_FEATURES-1) || !m_valid || m_ready.
  - This is a combinational path from m_ready to s_ready and is permitted.
- Accepted beat with idx < NUM_FEATURES-1 and s_last=0: write code into assembly slot idx; idx++.
- Accepted beat with idx == NUM_FEATURES-1 and s_last=1:
  - m_data <= assembly with slot 15 replaced by the current code.
  - m_valid <= 1; idx <= 0; assembly cleared.
  - The vector is visible on the cycle after the last beat (latency 1).
- Output hold: while m_valid && !m_ready, m_data and m_valid are stable.
  - Beats 0..14 of the next frame may still be accepted during the hold (overlap).
- m_valid clears on handshake unless a new vector loads the same cycle; in that case m_valid stays 1 with the new data.
- Framing errors:
  - s_last=1 at idx != NUM_FEATURES-1, or s_last=0 at idx == NUM_FEATURES-1.
  - Response: the beat is consumed, the partial vector is discarded (assembly cleared, idx=0), frame_err pulses for 1 cycle, and m_valid/m_data are unaffected.
- Config writes:
  - Take effect on the next cycle.
  - A beat accepted in the same cycle as a write to its own threshold uses the old value.
  - Writes are allowed at any time, including mid-frame.
- Reset mid-frame or with m_valid high: everything returns to the reset state immediately, the pending vector is lost, and thresholds revert to their defaults.

Decomposition:
- Package jsc_pkg holds:
  - FEAT_W, CODE_W, NUM_FEATURES.
  - Default thresholds THR0/1/2_RST.
  - Typedefs feat_t (signed [FEAT_W-1:0]) and code_t ([CODE_W-1:0]).
- Sub-module jsc_feat_quant: purely combinational; inputs x and T0..T2, output code_t.
  - Instantiated once, on the selected feature's thresholds (muxed by idx).

Test Plan:
- Reset defaults, m_ready=1, 16 beats with values -20000, -1, 0, 16384 repeated 4× (s_last on beat 16) → m_data=32'hE4E4E4E4 one cycle after the last beat, m_valid high for 1 cycle.
- Backpressure: m_ready=0; send frame A then beats 0..14 of frame B → s_ready low at B beat 15, m_data holds A; raise m_ready → A handshakes, B's last beat is accepted the same cycle, B appears the next cycle.
- Early s_last at beat 5 → frame_err pulses once, m_valid stays 0; the next full frame produces the correct vector.
- Missing s_last at beat 16 → frame_err, no output; the following frame aligns from idx 0.
- Threshold write: feature 3 gets T2=100 (cfg_addr={3,2}), then feature 3 value 150 → code 3; value 50 → code 2; a write in the same cycle as feature 3's beat uses the old T2.
- Assert rst_n low at beat 8 while m_valid=1 → m_valid=0, m_data=0, thresholds back to defaults; a clean frame afterwards is correct.
